// File: rtl/stack_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : stack_ctrl
//  Purpose  : Word-level push/pop/clear controller for an N-bit 1-bit-wide
//             shift-register stack (sel 00 hold, 01 load, 10 shl, 11 shr).
//             Serialises pushed words into the stack MSB, rebuilds popped
//             words from the stack top bit OUT_M, and tracks occupancy.
//  Ports    : clk, rst (async, active-high)
//             push_req/push_data, pop_req, clr_req -> ack (comb), busy
//             pop_data/pop_done, count/full/empty
//             sel1/sel0/ILeft/IRight/load_data -> stack, OUT_M <- stack
//             ovf_err/unf_err (sticky, only with STACK_CTRL_ERR_EN)
//  Options  : `define STACK_CTRL_ERR_EN adds overflow/underflow error flags.
//  Revision : 1.0 - initial release
// ============================================================================
module stack_ctrl #(
    parameter int N     = 8,
    parameter int W     = 4,
    parameter int WORDS = N / W,
    localparam int CW   = $clog2(WORDS + 1),
    localparam int BCW  = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_req,
    input  logic [W-1:0]  push_data,
    input  logic          pop_req,
    input  logic          clr_req,
    output logic          ack,
    output logic          busy,
    output logic [W-1:0]  pop_data,
    output logic          pop_done,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          sel1,
    output logic          sel0,
    output logic          ILeft,
    output logic          IRight,
    output logic [N-1:0]  load_data,
`ifdef STACK_CTRL_ERR_EN
    output logic          ovf_err,
    output logic          unf_err,
`endif
    input  logic          OUT_M
);

    typedef enum logic [1:0] {
        S_CLR  = 2'd0,
        S_IDLE = 2'd1,
        S_PUSH = 2'd2,
        S_POP  = 2'd3
    } state_t;

    state_t         state_q;
    logic [BCW-1:0] bc_q;
    logic [W-1:0]   word_q;
    logic [W-1:0]   pop_data_q;
    logic [CW-1:0]  count_q;
    logic           pop_done_q;
`ifdef STACK_CTRL_ERR_EN
    logic           ovf_q;
    logic           unf_q;
`endif

    logic w_idle;
    logic w_full;
    logic w_empty;
    logic w_clr_acc;
    logic w_push_acc;
    logic w_pop_acc;
    logic w_last;

    assign w_idle  = (state_q == S_IDLE);
    assign w_full  = (count_q == CW'(WORDS));
    assign w_empty = (count_q == '0);
    assign w_last  = (bc_q == BCW'(W - 1));

    // Fixed priority clr > push > pop; a refused push does not block a pop.
    assign w_clr_acc  = w_idle && clr_req;
    assign w_push_acc = w_idle && !clr_req && push_req && !w_full;
    assign w_pop_acc  = w_idle && !clr_req && !w_push_acc && pop_req && !w_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_CLR;
            bc_q       <= '0;
            word_q     <= '0;
            pop_data_q <= '0;
            count_q    <= '0;
            pop_done_q <= 1'b0;
`ifdef STACK_CTRL_ERR_EN
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
`endif
        end else begin
            pop_done_q <= 1'b0;
            case (state_q)
                S_CLR: begin
                    count_q <= '0;
                    bc_q    <= '0;
                    state_q <= S_IDLE;
`ifdef STACK_CTRL_ERR_EN
                    ovf_q   <= 1'b0;
                    unf_q   <= 1'b0;
`endif
                end
                S_IDLE: begin
                    if (w_clr_acc) begin
                        state_q <= S_CLR;
                    end else if (w_push_acc) begin
                        word_q  <= push_data;
                        bc_q    <= '0;
                        state_q <= S_PUSH;
                    end else if (w_pop_acc) begin
                        bc_q    <= '0;
                        state_q <= S_POP;
                    end
`ifdef STACK_CTRL_ERR_EN
                    if (!clr_req && push_req && w_full) begin
                        ovf_q <= 1'b1;
                    end
                    if (!clr_req && !w_push_acc && pop_req && w_empty) begin
                        unf_q <= 1'b1;
                    end
`endif
                end
                S_PUSH: begin
                    if (w_last) begin
                        count_q <= count_q + CW'(1);
                        state_q <= S_IDLE;
                    end else begin
                        bc_q <= bc_q + BCW'(1);
                    end
                end
                S_POP: begin
                    // Top bit comes out MSB-first, so shifting it in from the
                    // LSB side restores the original bit order.
                    word_q <= {word_q[W-2:0], OUT_M};
                    if (w_last) begin
                        count_q    <= count_q - CW'(1);
                        pop_data_q <= {word_q[W-2:0], OUT_M};
                        pop_done_q <= 1'b1;
                        state_q    <= S_IDLE;
                    end else begin
                        bc_q <= bc_q + BCW'(1);
                    end
                end
                default: state_q <= S_CLR;
            endcase
        end
    end

    assign ack       = w_clr_acc || w_push_acc || w_pop_acc;
    assign busy      = !w_idle;
    assign pop_data  = pop_data_q;
    assign pop_done  = pop_done_q;
    assign count     = count_q;
    assign full      = w_full;
    assign empty     = w_empty;

    // CLR -> 01 (load zero), IDLE -> 00, PUSH -> 11 (shr), POP -> 10 (shl).
    // Reset forces CLR, so the stack is zeroed on every edge during reset.
    assign sel1      = (state_q == S_PUSH) || (state_q == S_POP);
    assign sel0      = (state_q == S_CLR)  || (state_q == S_PUSH);
    // LSB goes in first so bit W-1 ends on top of the stack.
    assign ILeft     = (state_q == S_PUSH) ? word_q[bc_q] : 1'b0;
    assign IRight    = 1'b0;
    assign load_data = '0;

`ifdef STACK_CTRL_ERR_EN
    assign ovf_err   = ovf_q;
    assign unf_err   = unf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stack_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stack_ctrl
//  Purpose  : Self-checking bench for stack_ctrl. A bit-level model of the
//             external shift-register stack closes the loop on OUT_M; a
//             word queue is the reference for ack, count and pop_data.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stack_ctrl;
    localparam int N     = 8;
    localparam int W     = 4;
    localparam int WORDS = N / W;
    localparam int CW    = $clog2(WORDS + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          push_req = 1'b0;
    logic [W-1:0]  push_data = '0;
    logic          pop_req = 1'b0;
    logic          clr_req = 1'b0;
    logic          ack;
    logic          busy;
    logic [W-1:0]  pop_data;
    logic          pop_done;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          sel1;
    logic          sel0;
    logic          ILeft;
    logic          IRight;
    logic [N-1:0]  load_data;
    logic          OUT_M;
`ifdef STACK_CTRL_ERR_EN
    logic          ovf_err;
    logic          unf_err;
`endif

    stack_ctrl #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .push_req  (push_req),
        .push_data (push_data),
        .pop_req   (pop_req),
        .clr_req   (clr_req),
        .ack       (ack),
        .busy      (busy),
        .pop_data  (pop_data),
        .pop_done  (pop_done),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .sel1      (sel1),
        .sel0      (sel0),
        .ILeft     (ILeft),
        .IRight    (IRight),
        .load_data (load_data),
`ifdef STACK_CTRL_ERR_EN
        .ovf_err   (ovf_err),
        .unf_err   (unf_err),
`endif
        .OUT_M     (OUT_M)
    );

    always #5 clk = ~clk;

    // Behaviour of the downstream 1-bit shift-register stack (MSB = top).
    logic [N-1:0] stk;
    always @(posedge clk) begin
        case ({sel1, sel0})
            2'b01:   stk <= load_data;
            2'b10:   stk <= {stk[N-2:0], IRight};
            2'b11:   stk <= {ILeft, stk[N-1:1]};
            default: stk <= stk;
        endcase
    end
    assign OUT_M = stk[N-1];

    // Word-level reference: LIFO of words plus sticky error flags.
    logic [W-1:0] model[$];
    logic [W-1:0] last_pop = '0;
    bit           m_ovf = 1'b0;
    bit           m_unf = 1'b0;
    int           n_tests = 0;
    int           n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_count"}, 32'(count), model.size());
        check({tag, "_full"},  32'(full),  32'(model.size() == WORDS));
        check({tag, "_empty"}, 32'(empty), 32'(model.size() == 0));
    endtask

    task automatic check_err(input string tag);
`ifdef STACK_CTRL_ERR_EN
        check({tag, "_ovf"}, 32'(ovf_err), 32'(m_ovf));
        check({tag, "_unf"}, 32'(unf_err), 32'(m_unf));
`endif
    endtask

    task automatic do_push(input logic [W-1:0] d);
        bit exp_ack;
        exp_ack = (model.size() < WORDS);
        @(posedge clk); #1;
        push_req = 1'b1; push_data = d;
        @(negedge clk);
        check("push_ack", 32'(ack), 32'(exp_ack));
        check("push_idle", 32'(busy), 0);
        @(posedge clk); #1;
        push_req = 1'b0; push_data = ~d;
        if (exp_ack) begin
            for (int i = 0; i < W; i++) begin
                @(negedge clk);
                check("push_sel", 32'({sel1, sel0}), 32'h3);
                check("push_ileft", 32'(ILeft), 32'(d[i]));
                check("push_busy", 32'(busy), 1);
                check("push_cnt_hold", 32'(count), model.size());
            end
            model.push_back(d);
        end else begin
            m_ovf = 1'b1;
        end
        @(negedge clk);
        check("push_end_sel", 32'({sel1, sel0}), 0);
        check("push_end_busy", 32'(busy), 0);
        check("push_end_ileft", 32'(ILeft), 0);
        check_flags("push");
        check_err("push");
    endtask

    task automatic do_pop();
        bit exp_ack;
        exp_ack = (model.size() > 0);
        @(posedge clk); #1;
        pop_req = 1'b1;
        @(negedge clk);
        check("pop_ack", 32'(ack), 32'(exp_ack));
        @(posedge clk); #1;
        pop_req = 1'b0;
        if (exp_ack) begin
            for (int i = 0; i < W; i++) begin
                @(negedge clk);
                check("pop_sel", 32'({sel1, sel0}), 32'h2);
                check("pop_iright", 32'(IRight), 0);
                check("pop_done_early", 32'(pop_done), 0);
                check("pop_data_hold", 32'(pop_data), 32'(last_pop));
            end
            last_pop = model.pop_back();
        end else begin
            m_unf = 1'b1;
        end
        @(negedge clk);
        check("pop_done", 32'(pop_done), 32'(exp_ack));
        check("pop_data", 32'(pop_data), 32'(last_pop));
        check("pop_end_sel", 32'({sel1, sel0}), 0);
        check("pop_end_busy", 32'(busy), 0);
        check_flags("pop");
        check_err("pop");
        if (exp_ack) begin
            @(negedge clk);
            check("pop_done_pulse", 32'(pop_done), 0);
        end
    endtask

    task automatic do_clr(input bit with_push);
        @(posedge clk); #1;
        clr_req = 1'b1; push_req = with_push; push_data = W'($urandom);
        @(negedge clk);
        check("clr_ack", 32'(ack), 1);
        @(posedge clk); #1;
        clr_req = 1'b0; push_req = 1'b0;
        @(negedge clk);
        check("clr_sel", 32'({sel1, sel0}), 32'h1);
        check("clr_busy", 32'(busy), 1);
        model.delete();
        m_ovf = 1'b0; m_unf = 1'b0;
        @(negedge clk);
        check("clr_end_busy", 32'(busy), 0);
        check_flags("clr");
        check_err("clr");
    endtask

    // Accept a push or pop, then hit rst in the third busy cycle.
    task automatic reset_mid(input bit is_pop);
        @(posedge clk); #1;
        if (is_pop) pop_req = 1'b1;
        else begin push_req = 1'b1; push_data = W'($urandom); end
        @(negedge clk);
        check("rmid_ack", 32'(ack), 1);
        @(posedge clk); #1;
        pop_req = 1'b0; push_req = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        model.delete();
        m_ovf = 1'b0; m_unf = 1'b0; last_pop = '0;
        @(negedge clk);
        check("rmid_sel", 32'({sel1, sel0}), 32'h1);
        check("rmid_busy", 32'(busy), 1);
        check("rmid_count", 32'(count), 0);
        check("rmid_done", 32'(pop_done), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rmid_clr_sel", 32'({sel1, sel0}), 32'h1);
        check("rmid_clr_done", 32'(pop_done), 0);
        @(negedge clk);
        check("rmid_idle_busy", 32'(busy), 0);
        check("rmid_idle_done", 32'(pop_done), 0);
        check("rmid_pop_data", 32'(pop_data), 0);
        check_flags("rmid");
        check_err("rmid");
    endtask

    initial begin
        int op;
        // Power-up reset: CLR drive and busy while held and one cycle after.
        #1 rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rst_sel", 32'({sel1, sel0}), 32'h1);
            check("rst_busy", 32'(busy), 1);
            check("rst_count", 32'(count), 0);
            check("rst_done", 32'(pop_done), 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_sel", 32'({sel1, sel0}), 32'h1);
        check("post_rst_busy", 32'(busy), 1);
        @(negedge clk);
        check("idle_sel", 32'({sel1, sel0}), 0);
        check("idle_busy", 32'(busy), 0);
        check_flags("idle");
        check_err("idle");

        // Directed scenarios.
        do_push(4'hA);
        do_pop();
        do_push(4'hA);
        do_push(4'h3);
        do_pop();
        do_pop();
        do_push(4'h5);
        do_push(4'h6);
        do_push(4'h7);
        do_pop();
        do_pop();
        do_pop();
        do_clr(1'b0);
        do_push(4'hC);
        do_clr(1'b1);
        reset_mid(1'b0);
        do_pop();
        do_push(4'h9);
        reset_mid(1'b1);

        // Randomised mix biased towards push/pop; depth 2 hits both limits.
        for (int k = 0; k < 60; k++) begin
            op = int'($urandom_range(0, 9));
            if (op == 0) do_clr(1'($urandom_range(0, 1)));
            else if (op <= 5) do_push(W'($urandom));
            else do_pop();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/stack_ctrl.md
# stack_ctrl

Word-level controller placed directly upstream of the 1-bit shift-register stack (N-bit shift register with parallel load, `sel` encoding 00 hold / 01 load / 10 shift left / 11 shift right). It accepts W-bit push, pop and clear commands. Each command is turned into the `sel1`/`sel0`/`ILeft`/`IRight`/`IN` drive sequence for that stack. On a pop, the controller rebuilds the word from the stack's top bit `OUT_M`. It also tracks occupancy, so `full` and `empty` are authoritative; the stack register itself has no reset.

## Interface
Parameters:
- `N`, 8: stack depth in bits; equals the stack's `N`.
- `W`, 4: word width; `N` is an integer multiple of `W`, and `W` ≥ 2.
- `WORDS`, N/W: derived word capacity.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `push_req` in 1: request to push `push_data`.
- `push_data` in W: word to push; captured on accept.
- `pop_req` in 1: request to pop.
- `clr_req` in 1: request to empty the stack.
- `ack` out 1: combinational; high in the IDLE cycle in which a request is accepted.
- `busy` out 1: high when the state is not IDLE.
- `pop_data` out W: last popped word; held until the next pop completes.
- `pop_done` out 1: registered, one-cycle pulse when `pop_data` updates.
- `count` out $clog2(WORDS+1): number of stored words.
- `full` out 1: `count == WORDS`.
- `empty` out 1: `count == 0`.
- `sel1`, `sel0` out 1 each: stack mode select.
- `ILeft` out 1: serial bit entering the stack MSB on shift right.
- `IRight` out 1: serial bit entering the stack LSB on shift left; constant 0.
- `load_data` out N: drives the stack `IN`; constant 0.
- `OUT_M` in 1: stack MSB, which is the top-of-stack bit.

## Operation
- **States:** CLR, IDLE, PUSH, POP. A bit counter `bc` runs 0..W-1, and a W-bit shift register holds the word in progress.
- **Reset:** state=CLR, `count`=0, `bc`=0, `pop_data`=0, `pop_done`=0, error flags 0.
- **CLR:** `sel`=01 with `load_data`=0, so the stack is zeroed. Next state is IDLE and `count` goes to 0.
- **IDLE:** `sel`=00, `ILeft`=0. Requests are sampled with priority clr > push > pop.
  - `clr_req`: go to CLR, `ack`=1.
  - `push_req` && !`full`: capture `push_data`, `bc`=0, go to PUSH, `ack`=1.
  - `pop_req` && !`empty`: `bc`=0, go to POP, `ack`=1.
  - A refused request gives `ack`=0 and no state change.
- **PUSH:** `sel`=11 (shift right).
  - `ILeft` = `push_data` bit `bc`, so bit 0 is sent first and bit W-1 ends on top.
  - When `bc`=W-1: `count`+1, go to IDLE.
- **POP:** `sel`=10 (shift left), `IRight`=0.
  - Each edge: word register ← {word[W-2:0], `OUT_M`}. The MSB is read first, so the word is rebuilt in its original order.
  - When `bc`=W-1: `count`-1, `pop_data` ← assembled word, `pop_done` pulses next cycle, go to IDLE.
- Requests arriving while `busy` are ignored and never queued. The requester holds its request until it sees `ack`, then drops it.
- `full` and `empty` are derived combinationally from `count`. `count` changes only at the last shift edge of a push or pop, or on CLR.

## Timing
- **Push:** accepted at cycle t; PUSH occupies t+1..t+W; `count` updates at the end of t+W; IDLE again at t+W+1. Total W+1 cycles per push.
- **Pop:** same cycle counts as a push. `pop_done` and the new `pop_data` are visible in cycle t+W+1.
- **Clear:** accepted at t; CLR at t+1; `count`=0 from t+2.
- **During reset:** `sel`=01 and `busy`=1, so the stack is loaded with zero on every clock edge.
- **After reset release:** one CLR cycle, then IDLE.
- **Reset mid-push or mid-pop:** the operation is aborted, `count`=0, stack zeroed, and no `pop_done` is issued.
- **Back-to-back:** the earliest next accept is the IDLE cycle t+W+1.

## Configuration
- `STACK_CTRL_ERR_EN` defined:
  - Adds outputs `ovf_err` and `unf_err`; both are sticky.
  - `ovf_err` sets when `push_req` is refused in IDLE because the stack is full, provided no `clr_req` is present that cycle.
  - `unf_err` sets when `pop_req` is refused in IDLE because the stack is empty, provided no higher-priority request is accepted that cycle.
  - Both clear on CLR.
- `STACK_CTRL_ERR_EN` undefined: the ports are absent and refused requests are silently dropped.

## Test plan
Values use N=8, W=4.
1. Assert `rst` for 3 cycles, then release → `sel`=01 and `busy`=1 during reset and for one cycle after; then `sel`=00, `busy`=0, `count`=0, `empty`=1.
2. Push 0xA → `ack` at t; `sel`=11 with `ILeft` sequence 0,1,0,1 over t+1..t+4; `count`=1 at t+5.
3. Push 0xA, push 0x3, pop, pop → `pop_data`=0x3 then 0xA, each with a `pop_done` pulse; finally `count`=0, `empty`=1.
4. Push 0x5, push 0x6 (`full`=1), push 0x7 → `ack`=0 and `sel` stays 00; `ovf_err`=1 if `STACK_CTRL_ERR_EN`. A following pop returns 0x6.
5. `pop_req` while empty → `ack`=0 and no `pop_done`; `unf_err`=1 if enabled. Then `clr_req` → flags clear.
6. `clr_req` and `push_req` together in IDLE → CLR wins and `count`=0. Separately, assert `rst` at the third PUSH cycle → `count`=0, CLR, then IDLE, and a later pop is refused.
